// File: rtl/bm_dag4_stim_pkg.sv
// bm_dag4_stim_pkg: shared FSM states, LFSR constants and the LFSR/MISR step function
package bm_dag4_stim_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
  localparam int DRAIN_CYCLES = 3;
  localparam logic [LFSR_W-1:0] SEED_ZERO_SUB = 8'h01;
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/bm_dag4_stim_if.sv
// bm_dag4_stim_if: stimulus/response bundle between the generator and the DAG under test
interface bm_dag4_stim_if #(parameter int BITS = 2);
  logic            i_start;
  logic            o_busy;
  logic            o_done;
  logic            o_vec_valid;
  logic [BITS-1:0] o_a_out;
  logic [BITS-1:0] o_b_out;
  logic            o_c_out;
  logic            o_d_out;
  logic [BITS-1:0] i_res0_in;
  logic            i_res1_in;
  logic [7:0]      o_signature;
  logic [15:0]     o_vec_count;
  modport master(output i_start, i_res0_in, i_res1_in,
                 input o_busy, o_done, o_vec_valid, o_a_out, o_b_out, o_c_out, o_d_out, o_signature, o_vec_count);
  modport slave(input i_start, i_res0_in, i_res1_in,
                output o_busy, o_done, o_vec_valid, o_a_out, o_b_out, o_c_out, o_d_out, o_signature, o_vec_count);
endinterface

// File: rtl/bm_dag4_lfsr8.sv
// bm_dag4_lfsr8: 8-bit Fibonacci LFSR with synchronous load and step enable
module bm_dag4_lfsr8
  import bm_dag4_stim_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_en,
  input  logic [LFSR_W-1:0] i_seed,
  output logic [LFSR_W-1:0] o_state
);
  logic [LFSR_W-1:0] r_state;
  // load wins over stepping so a fresh run always begins at the seed
  always_ff @(posedge clock)
    r_state <= (reset || i_load) ? i_seed : i_en ? lfsr_next(r_state) : r_state;
  assign o_state = r_state;
endmodule

// File: rtl/bm_dag4_stim.sv
// bm_dag4_stim: LFSR vector generator for a 4-input DAG with optional MISR (macro BM_DAG4_STIM_MISR_EN)
module bm_dag4_stim
  import bm_dag4_stim_pkg::*;
#(
  parameter int          BITS    = 2,
  parameter int          NUM_VEC = 16,
  parameter logic [7:0]  SEED    = 8'hA5
)(
  input logic           clock,
  input logic           reset,
  bm_dag4_stim_if.slave bus
);
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? SEED_ZERO_SUB : SEED;
  state_t            r_state, w_state_d;
  logic [1:0]        r_drain;
  logic              r_vv;
  logic [BITS-1:0]   r_a, r_b;
  logic              r_c, r_d;
  logic [15:0]       r_cnt;
  logic [2:0]        r_rv;
  logic [LFSR_W-1:0] w_lfsr, w_vec;
  logic              w_start, w_last, w_vv_d;
  assign w_start = (r_state == S_IDLE) && bus.i_start;
  assign w_last  = r_vv && (r_cnt == 16'(NUM_VEC - 1));
  assign w_vv_d  = w_start || (r_vv && !w_last);
  assign w_vec   = w_start ? SEED_EFF : lfsr_next(w_lfsr);
  bm_dag4_lfsr8 u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_start),
    .i_en    (r_vv),
    .i_seed  (SEED_EFF),
    .o_state (w_lfsr)
  );
  // state register
  always_ff @(posedge clock)
    r_state <= reset ? S_IDLE : w_state_d;
  // next state: one pass IDLE -> RUN -> DRAIN -> DONE -> IDLE
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.i_start) w_state_d = S_RUN;
      S_RUN:   if (w_last) w_state_d = S_DRAIN;
      S_DRAIN: if (r_drain == 2'(DRAIN_CYCLES - 1)) w_state_d = S_DONE;
      default: w_state_d = S_IDLE;
    endcase
  end
  // drain timer, vector counter and result-valid delay line
  always_ff @(posedge clock) begin
    r_drain <= (!reset && r_state == S_DRAIN) ? r_drain + 2'd1 : 2'd0;
    r_cnt   <= (reset || w_start) ? 16'd0 : r_vv ? r_cnt + 16'd1 : r_cnt;
    r_rv    <= reset ? 3'd0 : {r_rv[1:0], r_vv};
  end
  // vector outputs follow the LFSR's next value and hold between vectors
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vv <= 1'b0;
      r_a  <= '0;
      r_b  <= '0;
      r_c  <= 1'b0;
      r_d  <= 1'b0;
    end else begin
      r_vv <= w_vv_d;
      if (w_vv_d) begin
        r_a <= w_vec[BITS-1:0];
        r_b <= w_vec[2*BITS-1:BITS];
        r_c <= w_vec[2*BITS];
        r_d <= w_vec[2*BITS+1];
      end
    end
  end
  assign bus.o_busy      = r_state != S_IDLE;
  assign bus.o_done      = r_state == S_DONE;
  assign bus.o_vec_valid = r_vv;
  assign bus.o_a_out     = r_a;
  assign bus.o_b_out     = r_b;
  assign bus.o_c_out     = r_c;
  assign bus.o_d_out     = r_d;
  assign bus.o_vec_count = r_cnt;
  logic w_unused_vec;
  assign w_unused_vec = ^w_vec;
`ifdef BM_DAG4_STIM_MISR_EN
  logic [7:0] r_sig;
  // MISR folds each returned result into the signature as it arrives
  always_ff @(posedge clock)
    r_sig <= (reset || w_start) ? 8'h00 :
             r_rv[2] ? lfsr_next(r_sig) ^ 8'({bus.i_res1_in, bus.i_res0_in}) : r_sig;
  assign bus.o_signature = r_sig;
`else
  logic w_unused_res;
  assign w_unused_res = ^{bus.i_res1_in, bus.i_res0_in, r_rv};
  assign bus.o_signature = 8'h00;
`endif
endmodule

// File: tb/tb_bm_dag4_stim.sv
// tb_bm_dag4_stim: scoreboard bench for bm_dag4_stim (NUM_VEC=4, SEED=A5 and SEED=0 instances)
module tb_bm_dag4_stim;
  localparam int BITS = 2;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  logic [5:0] q[$];
  logic [5:0] v0, v1;
  bm_dag4_stim_if #(.BITS(BITS)) bus ();
  bm_dag4_stim_if #(.BITS(BITS)) bus0 ();
  bm_dag4_stim #(.BITS(BITS), .NUM_VEC(4), .SEED(8'hA5)) u_dut (.clock(clock), .reset(reset), .bus(bus));
  bm_dag4_stim #(.BITS(BITS), .NUM_VEC(4), .SEED(8'h00)) u_dut0 (.clock(clock), .reset(reset), .bus(bus0));
  always #5 clock = ~clock;

  task automatic push_vectors(input logic [7:0] seed);
    logic [7:0] m;
    m = seed;
    for (int i = 0; i < 4; i++) begin
      q.push_back({m[1:0], m[3:2], m[4], m[5]});
      m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic do_run(input int restart_j, input int flip_j, output logic [7:0] sig);
    int idx;
    logic [5:0] e, got;
    idx = 0;
    @(negedge clock);
    bus.i_start = 1'b1;
    push_vectors(8'hA5);
    for (int j = 1; j <= 10; j++) begin
      @(negedge clock);
      n_vec++;
      if (bus.o_vec_valid !== (j <= 4)) begin
        n_bad++;
        $display("FAIL vec_valid j=%0d got %b exp %b", j, bus.o_vec_valid, j <= 4);
      end
      n_vec++;
      if (bus.o_busy !== (j <= 8)) begin
        n_bad++;
        $display("FAIL busy j=%0d got %b exp %b", j, bus.o_busy, j <= 8);
      end
      n_vec++;
      if (bus.o_done !== (j == 8)) begin
        n_bad++;
        $display("FAIL done j=%0d got %b exp %b", j, bus.o_done, j == 8);
      end
      if (bus.o_vec_valid === 1'b1) begin
        got = {bus.o_a_out, bus.o_b_out, bus.o_c_out, bus.o_d_out};
        if (idx == 0) v0 = got;
        if (idx == 1) v1 = got;
        idx++;
        n_vec++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL vector_extra got %b exp none", got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            n_bad++;
            $display("FAIL vector idx=%0d got %b exp %b", idx - 1, got, e);
          end
        end
      end
      bus.i_start   = (j == restart_j);
      bus.i_res0_in = BITS'(j * 3 + 1) ^ ((j == flip_j) ? 2'b01 : 2'b00);
      bus.i_res1_in = j[1];
    end
    n_vec++;
    if (bus.o_vec_count !== 16'd4) begin
      n_bad++;
      $display("FAIL vec_count got %0d exp 4", bus.o_vec_count);
    end
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL vector_missing got %0d left exp 0", q.size());
      q.delete();
    end
    sig = bus.o_signature;
  endtask

  task automatic test_reset;
    do_reset();
    repeat (3) @(negedge clock);
    n_vec++;
    if ({bus.o_busy, bus.o_done, bus.o_vec_valid, bus.o_a_out, bus.o_b_out, bus.o_c_out, bus.o_d_out} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got %b exp 0", {bus.o_busy, bus.o_done, bus.o_vec_valid, bus.o_a_out, bus.o_b_out, bus.o_c_out, bus.o_d_out});
    end
    n_vec++;
    if (bus.o_signature !== 8'h00 || bus.o_vec_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_sig_cnt got %h/%0d exp 00/0", bus.o_signature, bus.o_vec_count);
    end
    n_vec++;
    if ({bus0.o_busy, bus0.o_vec_valid, bus0.o_a_out, bus0.o_b_out} !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_dut0 got %b exp 0", {bus0.o_busy, bus0.o_vec_valid, bus0.o_a_out, bus0.o_b_out});
    end
  endtask

  task automatic test_run;
    logic [7:0] s;
    do_run(0, 0, s);
  endtask

  task automatic test_first_vectors;
    n_vec++;
    if (v0 !== 6'b01_01_0_1) begin
      n_bad++;
      $display("FAIL first_vector got %b exp 010101", v0);
    end
    n_vec++;
    if (v1 !== 6'b10_10_0_0) begin
      n_bad++;
      $display("FAIL second_vector got %b exp 101000", v1);
    end
  endtask

  task automatic test_busy_start;
    logic [7:0] s;
    do_run(2, 0, s);
  endtask

  task automatic test_back_to_back;
    logic [7:0] s;
    do_run(0, 0, s);
    do_run(0, 0, s);
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    bus.i_start = 1'b1;
    @(negedge clock);
    bus.i_start = 1'b0;
    @(negedge clock);
    n_vec++;
    if (bus.o_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_busy got %b exp 1", bus.o_busy);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_vec++;
    if ({bus.o_busy, bus.o_done, bus.o_vec_valid, bus.o_a_out, bus.o_b_out, bus.o_c_out, bus.o_d_out} !== 9'd0 || bus.o_vec_count !== 16'd0) begin
      n_bad++;
      $display("FAIL mid_reset got %b cnt %0d exp 0", {bus.o_busy, bus.o_done, bus.o_vec_valid, bus.o_a_out, bus.o_b_out, bus.o_c_out, bus.o_d_out}, bus.o_vec_count);
    end
    for (int j = 0; j < 12; j++) begin
      @(negedge clock);
      n_vec++;
      if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL aborted_run j=%0d got done %b busy %b exp 0 0", j, bus.o_done, bus.o_busy);
      end
    end
  endtask

  task automatic test_zero_seed;
    @(negedge clock);
    bus0.i_start = 1'b1;
    @(negedge clock);
    bus0.i_start = 1'b0;
    n_vec++;
    if ({bus0.o_vec_valid, bus0.o_a_out, bus0.o_b_out, bus0.o_c_out, bus0.o_d_out} !== 7'b1_01_00_0_0) begin
      n_bad++;
      $display("FAIL zero_seed got %b exp 1010000", {bus0.o_vec_valid, bus0.o_a_out, bus0.o_b_out, bus0.o_c_out, bus0.o_d_out});
    end
    repeat (12) @(negedge clock);
  endtask

  task automatic test_misr;
    logic [7:0] s1, s2, s3;
    do_run(0, 0, s1);
    do_run(0, 0, s2);
    do_run(0, 5, s3);
`ifdef BM_DAG4_STIM_MISR_EN
    n_vec++;
    if (s1 !== s2) begin
      n_bad++;
      $display("FAIL misr_repeat got %h exp %h", s2, s1);
    end
    n_vec++;
    if (s1 === 8'h00) begin
      n_bad++;
      $display("FAIL misr_nonzero got %h exp nonzero", s1);
    end
    n_vec++;
    if (s3 === s1) begin
      n_bad++;
      $display("FAIL misr_flip got %h exp not %h", s3, s1);
    end
`else
    n_vec++;
    if (s1 !== 8'h00 || s3 !== 8'h00) begin
      n_bad++;
      $display("FAIL sig_tied got %h/%h exp 00/00", s1, s3);
    end
`endif
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_res0_in = '0;
    bus.i_res1_in = 1'b0;
    bus0.i_start = 1'b0;
    bus0.i_res0_in = '0;
    bus0.i_res1_in = 1'b0;
    test_reset();
    test_run();
    test_first_vectors();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    test_zero_seed();
    test_misr();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/bm_dag4_stim.md
BM_DAG4_STIM -- requirements
Module: bm_dag4_stim

Interface
REQ-001 Parameter BITS, default 2, operand width of a_out/b_out/res0_in; legal range 1..3.
REQ-002 Parameter NUM_VEC, default 16, vectors issued per run; legal range 1..65535.
REQ-003 Parameter SEED, default 8'hA5, LFSR load value; a value of 0 SHALL be replaced by 8'h01.
REQ-004 clock  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  run request, sampled only in IDLE.
REQ-007 busy  output  1  high in RUN, DRAIN and DONE.
REQ-008 done  output  1  single-cycle pulse in DONE.
REQ-009 vec_valid  output  1  a/b/c/d_out carry a new vector this cycle.
REQ-010 a_out  output  BITS  operand A (lfsr[BITS-1:0]).
REQ-011 b_out  output  BITS  operand B (lfsr[2*BITS-1:BITS]).
REQ-012 c_out  output  1  lfsr[2*BITS].
REQ-013 d_out  output  1  lfsr[2*BITS+1].
REQ-014 res0_in  input  BITS  returned DAG result 0.
REQ-015 res1_in  input  1  returned DAG result 1.
REQ-016 signature  output  8  MISR compaction of returned results.
REQ-017 vec_count  output  16  vectors issued in the current/last run.

Function
REQ-018 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN after the NUM_VEC-th vector; DRAIN->DONE after 3 cycles; DONE->IDLE after 1 cycle.
REQ-019 start sampled high at edge k SHALL give vec_valid high on cycles k+1..k+NUM_VEC, DRAIN on k+NUM_VEC+1..k+NUM_VEC+3, done on k+NUM_VEC+4.
REQ-020 start while busy SHALL be ignored; no restart, no counter or LFSR disturbance.
REQ-021 On start acceptance: LFSR reloads SEED, vec_count and signature clear to 0.
REQ-022 LFSR 8-bit Fibonacci, shift left, new bit0 = b7^b5^b4^b3, advancing once per cycle vec_valid is high.
REQ-023 Outputs a/b/c/d SHALL be registered, driven directly from LFSR bits; they hold their value when vec_valid is low.
REQ-024 Result-valid SHALL be vec_valid delayed exactly 3 cycles (3-stage shift register), matching the DAG's worst-case latency.
REQ-025 vec_count increments by 1 per issued vector; holds its value in DRAIN, DONE and IDLE until the next start.

Reset
REQ-026 reset SHALL force IDLE, busy=0, done=0, vec_valid=0, a/b/c/d_out=0, signature=0, vec_count=0, LFSR=SEED, result-valid pipeline cleared.
REQ-027 reset mid-run SHALL abort immediately; no done pulse is generated for the aborted run.

Configuration
REQ-028 Macro BM_DAG4_STIM_MISR_EN defined: on each result-valid cycle, signature <= {sig[6:0], sig7^sig5^sig4^sig3} XOR zero-extended {res1_in, res0_in}.
REQ-029 Macro BM_DAG4_STIM_MISR_EN undefined: no MISR logic; signature tied to 8'h00; res0_in/res1_in unused.

Structure
REQ-030 Shared package holds FSM state enum, LFSR width (8), LFSR tap mask, DRAIN_CYCLES (3), zero-seed substitute (8'h01).
REQ-031 One sub-module bm_dag4_lfsr8 (load, enable, seed in; 8-bit state out); the MISR stays inline.

Verification
REQ-032 Reset, then hold idle: all outputs 0, busy=0, signature=8'h00.
REQ-033 NUM_VEC=4, start at edge k: vec_valid on k+1..k+4, done only on k+8, vec_count=4, busy low at k+9.
REQ-034 SEED=8'hA5, BITS=2: first vector a=2'b01 b=2'b01 c=0 d=1; second (LFSR 8'h4A) a=2'b10 b=2'b10 c=0 d=0.
REQ-035 start pulsed at k+2 of a running 4-vector run: timing identical to REQ-033; reset at k+2: outputs return to reset values next cycle, no done.
REQ-036 SEED=0: first vector taken from 8'h01 (a=2'b01, b=0, c=0, d=0).
REQ-037 With MISR_EN, two runs with identical res inputs: identical nonzero signatures; one flipped res0_in bit: signature differs; without MISR_EN signature stays 8'h00.
